text_vram_arb: RTL and testbench

TEXT_VRAM_ARB -- requirements
Module: text_vram_arb

---
 rtl/text_vram_arb_if.sv | 24 ++
 rtl/text_vram_arb.sv | 131 +++++++++++++
 tb/tb_text_vram_arb.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/text_vram_arb_if.sv
// Host write / clear handshake and single-port text RAM bus of the text VRAM arbiter.
`timescale 1ns/1ps
interface text_vram_arb_if;
  logic        WREQ_i;
  logic [10:0] WADR_i;
  logic [7:0]  WDAT_i;
  logic        WACK_o;
  logic        CLR_REQ_i;
  logic        BUSY_o;
  logic [10:0] RAM_ADR_o;
  logic        RAM_WE_o;
  logic [7:0]  RAM_WD_o;
  logic [7:0]  RAM_RD_i;

  modport slave (
    input  WREQ_i, WADR_i, WDAT_i, CLR_REQ_i, RAM_RD_i,
    output WACK_o, BUSY_o, RAM_ADR_o, RAM_WE_o, RAM_WD_o
  );

  modport master (
    output WREQ_i, WADR_i, WDAT_i, CLR_REQ_i, RAM_RD_i,
    input  WACK_o, BUSY_o, RAM_ADR_o, RAM_WE_o, RAM_WD_o
  );
endinterface

// File: rtl/text_vram_arb.sv
// Text VRAM arbiter: one RAM access per enabled cycle, video fetch > clear engine > host write.
`timescale 1ns/1ps
module text_vram_arb #(
  parameter int unsigned C_COLS  = 40,
  parameter int unsigned C_ROWS  = 30,
  parameter logic [7:0]  C_BLANK = 8'h20
) (
  input  logic             CK_i,
  input  logic             RST_i,
  input  logic             CK_EE_i,
  input  logic [9:0]       HCTRs_i,
  input  logic [8:0]       VCTRs_i,
  text_vram_arb_if.slave   bus,
  output logic [7:0]       CHAR_o,
  output logic             CHAR_VLD_o
);

  localparam logic [9:0]  H_ACT = 10'(C_COLS * 16);
  localparam logic [8:0]  V_ACT = 9'(C_ROWS * 8);
  localparam logic [10:0] CELLS = 11'(C_COLS * C_ROWS);
  localparam logic [10:0] LAST  = CELLS - 11'd1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } clr_state_e;

  clr_state_e  state_q;
  logic [10:0] clr_cnt_q;
  logic        busy_q;
  logic        wack_q;
  logic [10:0] adr_q;
  logic [7:0]  wd_q;
  logic        we_q;
  logic        vld1_q;
  logic        vld2_q;
  logic        char_vld_q;
  logic [7:0]  char_q;

  logic        vid_slot;
  logic [4:0]  row;
  logic [5:0]  col;
  logic [10:0] vid_adr;
  logic        clr_wr;
  logic        host_gnt;
  logic [10:0] adr_d;
  logic [7:0]  wd_d;
  logic        we_d;

  always_comb begin
    row      = VCTRs_i[7:3];
    col      = HCTRs_i[9:4];
    vid_slot = (HCTRs_i[3:0] == 4'd0) && (HCTRs_i < H_ACT) && (VCTRs_i < V_ACT);
    // row*40 as shift-and-add: row*32 + row*8
    vid_adr  = {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};
    clr_wr   = !vid_slot && (state_q == S_CLEAR);
    // the cycle showing WACK is never a grant, so a held WREQ re-arms one cycle later
    host_gnt = !vid_slot && !busy_q && bus.WREQ_i && !wack_q;

    adr_d = adr_q;
    wd_d  = wd_q;
    we_d  = 1'b0;
    if (vid_slot) begin
      adr_d = vid_adr;
    end else if (clr_wr) begin
      adr_d = clr_cnt_q;
      wd_d  = C_BLANK;
      we_d  = 1'b1;
    end else if (host_gnt) begin
      adr_d = bus.WADR_i;
      wd_d  = bus.WDAT_i;
      we_d  = (bus.WADR_i < CELLS);
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state_q    <= S_IDLE;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b0;
      wack_q     <= 1'b0;
      adr_q      <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      char_vld_q <= 1'b0;
      char_q     <= '0;
    end else if (CK_EE_i) begin
      adr_q      <= adr_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      wack_q     <= host_gnt;
      vld1_q     <= vid_slot;
      vld2_q     <= vld1_q;
      char_vld_q <= vld2_q;
      if (vld2_q) begin
        char_q <= bus.RAM_RD_i;
      end
      unique case (state_q)
        S_IDLE: begin
          if (bus.CLR_REQ_i) begin
            state_q   <= S_CLEAR;
            busy_q    <= 1'b1;
            clr_cnt_q <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_wr) begin
            if (clr_cnt_q == LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              clr_cnt_q <= clr_cnt_q + 11'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.WACK_o    = wack_q;
  assign bus.BUSY_o    = busy_q;
  assign bus.RAM_ADR_o = adr_q;
  assign bus.RAM_WE_o  = we_q;
  assign bus.RAM_WD_o  = wd_q;
  assign CHAR_o        = char_q;
  assign CHAR_VLD_o    = char_vld_q;

endmodule

// File: tb/tb_text_vram_arb.sv
// Directed bench for text_vram_arb with a behavioural single-port RAM model.
`timescale 1ns/1ps
module tb_text_vram_arb;
  logic       ck = 1'b0;
  logic       rst;
  logic       ee;
  logic [9:0] hctr;
  logic [8:0] vctr;
  logic [7:0] char_o;
  logic       char_vld;

  text_vram_arb_if bus();

  text_vram_arb #(.C_COLS(40), .C_ROWS(30), .C_BLANK(8'h20)) dut (
    .CK_i(ck), .RST_i(rst), .CK_EE_i(ee), .HCTRs_i(hctr), .VCTRs_i(vctr),
    .bus(bus), .CHAR_o(char_o), .CHAR_VLD_o(char_vld)
  );

  always #5 ck = ~ck;

  // RAM: read data appears one enabled cycle after the address; reset preloads a pattern
  logic [7:0] mem [0:2047];
  logic [7:0] ram_rd;
  always @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'(i) ^ 8'h5A;
      ram_rd <= '0;
    end else if (ee) begin
      if (bus.RAM_WE_o) mem[bus.RAM_ADR_o] <= bus.RAM_WD_o;
      ram_rd <= mem[bus.RAM_ADR_o];
    end
  end
  assign bus.RAM_RD_i = ram_rd;

  int   n_vec = 0;
  int   n_err = 0;
  logic run;
  logic mon_en;
  int   exp_clr;
  int   clr_err;
  int   wack_busy;
  int   mem_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; writes seen afterwards belong to the inputs presented before it
  task automatic tick();
    logic slot;
    logic en;
    slot = (hctr[3:0] == 4'd0) && (hctr < 10'd640) && (vctr < 9'd240);
    en   = ee;
    @(posedge ck); #1;
    if (en && !rst && mon_en) begin
      if (bus.RAM_WE_o && !bus.WACK_o) begin
        if (exp_clr >= 1200 || slot || bus.RAM_ADR_o !== 11'(exp_clr) || bus.RAM_WD_o !== 8'h20)
          clr_err++;
        exp_clr++;
      end
      if (bus.WACK_o && bus.BUSY_o) wack_busy++;
    end
    if (en && run) begin
      if (hctr == 10'd779) begin
        hctr = '0;
        vctr = (vctr == 9'd262) ? 9'd0 : vctr + 9'd1;
      end else begin
        hctr = hctr + 10'd1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; ee = 1'b1; hctr = 10'd700; vctr = 9'd250;
    bus.WREQ_i = 1'b0; bus.WADR_i = '0; bus.WDAT_i = '0; bus.CLR_REQ_i = 1'b0;
    run = 1'b0; mon_en = 1'b0; exp_clr = 0; clr_err = 0; wack_busy = 0; mem_bad = 0;

    // reset
    tick(); tick();
    chk("rst_wack", bus.WACK_o, 0);
    chk("rst_busy", bus.BUSY_o, 0);
    chk("rst_we", bus.RAM_WE_o, 0);
    chk("rst_adr", bus.RAM_ADR_o, 0);
    chk("rst_wd", bus.RAM_WD_o, 0);
    chk("rst_char", char_o, 0);
    chk("rst_vld", char_vld, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_we", bus.RAM_WE_o, 0);

    // video fetch at top-left
    hctr = 10'd0; vctr = 9'd0;
    tick();
    chk("fetch0_adr", bus.RAM_ADR_o, 0);
    chk("fetch0_we", bus.RAM_WE_o, 0);
    hctr = 10'd1;
    tick();
    chk("fetch0_vld_early", char_vld, 0);
    tick();
    chk("fetch0_vld", char_vld, 1);
    chk("fetch0_char", char_o, 8'h5A);
    tick();
    chk("fetch0_vld_drop", char_vld, 0);

    // bottom-right cell
    hctr = 10'd624; vctr = 9'd239;
    tick();
    chk("fetch_last_adr", bus.RAM_ADR_o, 1199);
    hctr = 10'd625;
    tick(); tick();
    chk("fetch_last_vld", char_vld, 1);
    chk("fetch_last_char", char_o, 8'hF5);

    // row 2, col 10
    hctr = 10'd160; vctr = 9'd17;
    tick();
    chk("fetch_mid_adr", bus.RAM_ADR_o, 90);
    hctr = 10'd700; vctr = 9'd250;
    tick(); tick();
    chk("fetch_mid_vld", char_vld, 1);
    chk("fetch_mid_char", char_o, 8'h00);

    // line 240 and pixel 640 are outside the active area
    hctr = 10'd0; vctr = 9'd240;
    tick(); tick(); tick();
    chk("no_slot_v240_vld", char_vld, 0);
    hctr = 10'd640; vctr = 9'd0;
    tick();
    chk("no_slot_h640_adr", bus.RAM_ADR_o, 90);
    tick(); tick();
    chk("no_slot_h640_vld", char_vld, 0);

    // host request collides with the video slot at pixel 16
    hctr = 10'd16; vctr = 9'd0;
    bus.WREQ_i = 1'b1; bus.WADR_i = 11'd300; bus.WDAT_i = 8'h3C;
    tick();
    chk("coll16_adr", bus.RAM_ADR_o, 1);
    chk("coll16_wack", bus.WACK_o, 0);
    chk("coll16_we", bus.RAM_WE_o, 0);
    hctr = 10'd17;
    tick();
    chk("coll18_wack", bus.WACK_o, 1);
    chk("coll18_we", bus.RAM_WE_o, 1);
    chk("coll18_adr", bus.RAM_ADR_o, 300);
    chk("coll18_wd", bus.RAM_WD_o, 8'h3C);
    bus.WREQ_i = 1'b0; hctr = 10'd18;
    tick();
    chk("coll_wack_drop", bus.WACK_o, 0);

    // back-to-back host writes with WREQ held
    hctr = 10'd700; vctr = 9'd250;
    bus.WREQ_i = 1'b1; bus.WADR_i = 11'd5; bus.WDAT_i = 8'h11;
    tick();
    chk("b2b_wack1", bus.WACK_o, 1);
    chk("b2b_adr1", bus.RAM_ADR_o, 5);
    bus.WADR_i = 11'd6; bus.WDAT_i = 8'h22;
    tick();
    chk("b2b_gap_wack", bus.WACK_o, 0);
    chk("b2b_gap_we", bus.RAM_WE_o, 0);
    tick();
    chk("b2b_wack2", bus.WACK_o, 1);
    chk("b2b_adr2", bus.RAM_ADR_o, 6);
    chk("b2b_wd2", bus.RAM_WD_o, 8'h22);
    bus.WREQ_i = 1'b0;
    tick();

    // out-of-range address is acked but discarded
    bus.WREQ_i = 1'b1; bus.WADR_i = 11'd1200; bus.WDAT_i = 8'h99;
    tick();
    chk("oor_wack", bus.WACK_o, 1);
    chk("oor_we", bus.RAM_WE_o, 0);
    bus.WREQ_i = 1'b0;
    tick();
    chk("oor_wack_drop", bus.WACK_o, 0);

    // clock enable low holds the ack pulse
    bus.WREQ_i = 1'b1; bus.WADR_i = 11'd7; bus.WDAT_i = 8'h33;
    tick();
    chk("ee_wack", bus.WACK_o, 1);
    ee = 1'b0; bus.WREQ_i = 1'b0;
    tick(); tick();
    chk("ee_hold_wack", bus.WACK_o, 1);
    chk("ee_hold_we", bus.RAM_WE_o, 1);
    ee = 1'b1;
    tick();
    chk("ee_release_wack", bus.WACK_o, 0);
    chk("ee_release_we", bus.RAM_WE_o, 0);

    // clear request and host grant in the same idle cycle
    bus.WREQ_i = 1'b1; bus.WADR_i = 11'd40; bus.WDAT_i = 8'h44; bus.CLR_REQ_i = 1'b1;
    tick();
    chk("same_wack", bus.WACK_o, 1);
    chk("same_adr", bus.RAM_ADR_o, 40);
    chk("same_we", bus.RAM_WE_o, 1);
    chk("same_busy", bus.BUSY_o, 1);
    bus.WREQ_i = 1'b0; bus.CLR_REQ_i = 1'b0;
    tick();
    chk("clr1_adr", bus.RAM_ADR_o, 0);
    chk("clr1_wd", bus.RAM_WD_o, 8'h20);
    chk("clr1_we", bus.RAM_WE_o, 1);
    chk("clr1_wack", bus.WACK_o, 0);
    repeat (99) tick();
    chk("clr100_adr", bus.RAM_ADR_o, 99);
    ee = 1'b0;
    repeat (5) tick();
    chk("clr_ee_hold_adr", bus.RAM_ADR_o, 99);
    chk("clr_ee_hold_busy", bus.BUSY_o, 1);
    ee = 1'b1;
    tick();
    chk("clr_resume_adr", bus.RAM_ADR_o, 100);
    bus.CLR_REQ_i = 1'b1;
    tick();
    chk("clr_no_restart", bus.RAM_ADR_o, 101);
    bus.CLR_REQ_i = 1'b0; rst = 1'b1;
    tick();
    chk("abort_busy", bus.BUSY_o, 0);
    chk("abort_we", bus.RAM_WE_o, 0);
    rst = 1'b0;
    tick();
    chk("abort_after_we", bus.RAM_WE_o, 0);
    chk("abort_after_busy", bus.BUSY_o, 0);

    // full clear during running video with a pending host write
    hctr = 10'd100; vctr = 9'd10; run = 1'b1; mon_en = 1'b1;
    bus.CLR_REQ_i = 1'b1;
    tick();
    bus.CLR_REQ_i = 1'b0;
    chk("full_busy", bus.BUSY_o, 1);
    bus.WREQ_i = 1'b1; bus.WADR_i = 11'd500; bus.WDAT_i = 8'h77;
    for (int i = 0; i < 4000 && bus.BUSY_o; i++) tick();
    chk("full_busy_fall", bus.BUSY_o, 0);
    for (int i = 0; i < 20 && !bus.WACK_o; i++) tick();
    chk("full_host_wack", bus.WACK_o, 1);
    chk("full_host_adr", bus.RAM_ADR_o, 500);
    bus.WREQ_i = 1'b0;
    tick();
    chk("full_write_count", exp_clr, 1200);
    chk("full_write_errors", clr_err, 0);
    chk("full_wack_while_busy", wack_busy, 0);
    for (int i = 0; i < 1200; i++) begin
      if (mem[i] !== ((i == 500) ? 8'h77 : 8'h20)) mem_bad++;
    end
    chk("full_mem_contents", mem_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
